// File: rtl/oam_writer.sv
// rtl/oam_writer.sv - double-buffered sprite attribute memory with edit port and frame-synchronous bank swap
// Shadow bank takes edits; on commit the banks swap at frame_start and the new active bank is copied back.
module oam_writer #(
  parameter int OAM_DEPTH = 8,
  parameter int OAM_WIDTH = 32,
  localparam int IW = $clog2(OAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 commit,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [IW-1:0]        cmd_idx,
  input  logic [OAM_WIDTH-1:0] cmd_data,
  input  logic [IW-1:0]        oam_addr,
  output logic [OAM_WIDTH-1:0] oam_data,
  output logic                 pending,
  output logic                 swap_done
);

  typedef enum logic [0:0] {S_IDLE, S_COPY} state_t;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_MOVE   = 2'b01;
  localparam logic [1:0] OP_ENABLE = 2'b10;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_bank_sel;
  logic [IW-1:0]        r_cnt;
  logic                 r_pending;
  logic                 r_swap_done;
  logic [OAM_WIDTH-1:0] r_bank0 [OAM_DEPTH];
  logic [OAM_WIDTH-1:0] r_bank1 [OAM_DEPTH];

  logic                 w_cmd_ready;
  logic                 w_swap;
  logic                 w_cmd_fire;
  logic [OAM_WIDTH-1:0] w_shadow_word;
  logic [OAM_WIDTH-1:0] w_new_word;

  function automatic logic [OAM_WIDTH-1:0] f_merge(input logic [OAM_WIDTH-1:0] old_w,
                                                   input logic [1:0]           op,
                                                   input logic [OAM_WIDTH-1:0] d);
    logic [OAM_WIDTH-1:0] w;
    w = old_w;
    case (op)
      OP_WRITE:  w = d;
      OP_MOVE:   w[27:8] = d[27:8];
      OP_ENABLE: w[28] = d[28];
      default:   w[7:0] = d[7:0];
    endcase
    w[OAM_WIDTH-1] = 1'b0;
    return w;
  endfunction

  always_comb begin
    w_next_state = r_state;
    w_cmd_ready  = 1'b0;
    w_swap       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if ((r_pending || commit) && frame_start) begin
          w_swap       = 1'b1;
          w_next_state = S_COPY;
        end
      end
      S_COPY: begin
        if (r_cnt == IW'(OAM_DEPTH - 1)) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_cmd_fire    = cmd_valid && w_cmd_ready;
  assign w_shadow_word = r_bank_sel ? r_bank0[cmd_idx] : r_bank1[cmd_idx];
  assign w_new_word    = f_merge(w_shadow_word, cmd_op, cmd_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bank_sel  <= 1'b0;
      r_cnt       <= '0;
      r_pending   <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_swap_done <= w_swap;
      if (w_swap) begin
        r_bank_sel <= ~r_bank_sel;
        r_pending  <= 1'b0;
        r_cnt      <= '0;
      end else begin
        if (commit) r_pending <= 1'b1;
        if (r_state == S_COPY) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Edits and copy-back are exclusive: cmd_ready is low for the whole copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OAM_DEPTH; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
      end
    end else if (w_cmd_fire) begin
      if (r_bank_sel) r_bank0[cmd_idx] <= w_new_word;
      else            r_bank1[cmd_idx] <= w_new_word;
    end else if (r_state == S_COPY) begin
      if (r_bank_sel) r_bank0[r_cnt] <= r_bank1[r_cnt];
      else            r_bank1[r_cnt] <= r_bank0[r_cnt];
    end
  end

  assign oam_data  = r_bank_sel ? r_bank1[oam_addr] : r_bank0[oam_addr];
  assign cmd_ready = w_cmd_ready;
  assign pending   = r_pending;
  assign swap_done = r_swap_done;

endmodule
